ps2_key_ctrl: RTL and testbench
===============================

Name: ps2_key_ctrl

Overview:
- Consumer and sequencer for the PS/2 scancode FIFO.
- Pops raw Set-2 bytes using the keyboard's ready / nextdata_n handshake.
- Folds prefix bytes (E0 extended, F0 break, E1 Pause) into single key events.
- Tracks the currently held key, suppresses typematic repeats in the press counter, and reports FIFO overflow.
- Sits between the PS/2 keyboard receiver and the display/ASCII logic in top.

Parameters:
- CNT_W, 8: width of press_count.
- POP_GAP, 1: idle cycles after a pop before ready is sampled again; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  1 = consume bytes; 0 = stall in IDLE (FIFO keeps filling)
- kbd_ready  in  1  receiver FIFO non-empty
- kbd_data  in  8  receiver FIFO head byte
- kbd_overflow  in  1  receiver overflow flag
- kbd_nextdata_n  out  1  active-low pop strobe to receiver, registered
- clr_err  in  1  clears err_overflow
- key_valid  out  1  one-cycle event strobe
- key_code  out  8  scancode of event, valid with key_valid, held until next event
- key_ext  out  1  event had E0 prefix
- key_break  out  1  event is a release
- key_repeat  out  1  make of the already-held key (typematic)
- key_held  out  1  a key is currently held
- held_code  out  8  code of held key
- press_count  out  CNT_W  count of non-repeat make events, wraps
- err_overflow  out  1  sticky overflow indication

Behaviour:
- Reset (async, rst=1), all outputs and state:
  - kbd_nextdata_n=1; all other outputs 0.
  - State IDLE; flags ext_f, brk_f = 0; skip_cnt=0; gap counter 0.
- FSM states: IDLE, POP, GAP, DECODE.
  - IDLE: if en & kbd_ready, capture kbd_data into byte_r, drive kbd_nextdata_n=0 (registered, low for exactly one cycle), go to POP.
  - POP: kbd_nextdata_n=1; load gap counter with POP_GAP-1; go to GAP.
  - GAP: decrement; at 0 go to DECODE. This guarantees kbd_ready has deasserted if the FIFO drained. Never pop while in POP/GAP/DECODE.
  - DECODE: process byte_r (one cycle), then go to IDLE.
- Latency: kbd_ready to key_valid is 3+POP_GAP cycles for a terminal byte. Max throughput is one byte per 3+POP_GAP cycles.
- DECODE rules, in priority order:
  1. skip_cnt != 0: decrement, no event.
  2. byte E1: skip_cnt=7. Emit event code=E1, ext=0, break=0, repeat=0. press_count+1. Held state unchanged.
  3. byte E0: ext_f=1, no event.
  4. byte F0: brk_f=1, no event.
  5. byte in {00, AA, EE, FA, FE, FF}: discard, clear ext_f/brk_f, no event.
  6. Otherwise terminal: key_valid=1; key_code=byte; key_ext=ext_f; key_break=brk_f; clear both flags.
     - Make, with key_held and {ext,code} == held {ext,code}: key_repeat=1, press_count unchanged.
     - Make, other cases: key_repeat=0, press_count+1, held_code/held_ext updated, key_held=1.
     - Break matching held {ext,code}: key_held=0, held_code retained.
     - Break not matching: held state unchanged.
     - key_repeat=0 on all breaks.
- press_count wraps from 2^CNT_W-1 to 0.
- err_overflow:
  - Set on any cycle with kbd_overflow=1.
  - clr_err clears it; if both occur in the same cycle, set wins.
- en falls mid-sequence: the current byte completes through DECODE. Prefix flags and skip_cnt persist across the stall.
- rst mid-sequence: immediate return to reset values. kbd_nextdata_n returns to 1 asynchronously. Partial prefixes are discarded.

Test Plan:
- Feed 1C, F0, 1C (ready per byte), en=1:
  - Events: {1C, make, repeat=0}, then {1C, break}.
  - press_count=1; key_held 1 then 0.
  - kbd_nextdata_n low exactly 3 single cycles.
- Feed E0 75 E0 F0 75:
  - Events: {75, ext=1, make}, then {75, ext=1, break}.
  - key_held ends 0; no events emitted on the prefix bytes.
- Feed 1C 1C 1C F0 1C:
  - Repeat flags 0,1,1 on the makes.
  - press_count=1.
  - Break clears key_held.
- Feed 1C, 32, F0 1C:
  - held_code=32 after the second make.
  - Break of 1C leaves key_held=1, held_code=32.
  - press_count=2.
- Feed E1 14 77 E1 F0 14 F0 77 then 1C:
  - Exactly one E1 event, then a 1C make.
  - press_count=2.
- Pulse kbd_overflow:
  - err_overflow=1 until clr_err.
  - clr_err and kbd_overflow together keep it 1.
  - Assert rst during GAP: outputs return to 0 and kbd_nextdata_n to 1 immediately.

Source files
------------

// File: rtl/ps2_key_ctrl.sv
// PS/2 scancode sequencer: pops Set-2 bytes from the receiver FIFO, folds
// E0/F0/E1 prefixes into single key events, tracks the held key, counts
// non-repeat presses and keeps a sticky overflow flag.
module ps2_key_ctrl #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned POP_GAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             kbd_ready,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata_n,
    input  logic             clr_err,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_break,
    output logic             key_repeat,
    output logic             key_held,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] press_count,
    output logic             err_overflow
);

    localparam int unsigned GapW = (POP_GAP > 1) ? $clog2(POP_GAP) : 1;

    typedef enum logic [1:0] {StIdle, StPop, StGap, StDecode} state_e;

    state_e           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [2:0]       skip_q, skip_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic             valid_q, valid_d;
    logic [7:0]       code_q, code_d;
    logic             kext_q, kext_d;
    logic             kbrk_q, kbrk_d;
    logic             krep_q, krep_d;
    logic             held_q, held_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             held_ext_q, held_ext_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             key_match;
    logic             is_noise;

    // Terminal byte refers to the key currently held (same code and E0 prefix).
    assign key_match = held_q && (held_code_q == byte_q) && (held_ext_q == ext_q);

    // Keyboard status/ack bytes that never form a key event.
    assign is_noise = (byte_q == 8'h00) || (byte_q == 8'hAA) || (byte_q == 8'hEE) ||
                      (byte_q == 8'hFA) || (byte_q == 8'hFE) || (byte_q == 8'hFF);

    // Next-state, pop handshake and byte decode.
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        gap_d        = gap_q;
        skip_d       = skip_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        nextdata_n_d = 1'b1;
        valid_d      = 1'b0;
        code_d       = code_q;
        kext_d       = kext_q;
        kbrk_d       = kbrk_q;
        krep_d       = krep_q;
        held_d       = held_q;
        held_code_d  = held_code_q;
        held_ext_d   = held_ext_q;
        cnt_d        = cnt_q;
        err_d        = kbd_overflow ? 1'b1 : (clr_err ? 1'b0 : err_q);

        unique case (state_q)
            StIdle: begin
                if (en && kbd_ready) begin
                    byte_d       = kbd_data;
                    nextdata_n_d = 1'b0;
                    state_d      = StPop;
                end
            end
            StPop: begin
                gap_d   = GapW'(POP_GAP - 1);
                state_d = StGap;
            end
            // Wait long enough for kbd_ready to reflect the pop.
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StDecode;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            StDecode: begin
                state_d = StIdle;
                if (skip_q != 3'd0) begin
                    // Remaining bytes of the Pause sequence are swallowed.
                    skip_d = skip_q - 3'd1;
                end else if (byte_q == 8'hE1) begin
                    skip_d  = 3'd7;
                    valid_d = 1'b1;
                    code_d  = 8'hE1;
                    kext_d  = 1'b0;
                    kbrk_d  = 1'b0;
                    krep_d  = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                end else if (byte_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (is_noise) begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
                    code_d  = byte_q;
                    kext_d  = ext_q;
                    kbrk_d  = brk_q;
                    krep_d  = 1'b0;
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    if (!brk_q) begin
                        if (key_match) begin
                            krep_d = 1'b1;
                        end else begin
                            cnt_d       = cnt_q + 1'b1;
                            held_d      = 1'b1;
                            held_code_d = byte_q;
                            held_ext_d  = ext_q;
                        end
                    end else if (key_match) begin
                        held_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            byte_q       <= 8'h00;
            gap_q        <= '0;
            skip_q       <= 3'd0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            nextdata_n_q <= 1'b1;
            valid_q      <= 1'b0;
            code_q       <= 8'h00;
            kext_q       <= 1'b0;
            kbrk_q       <= 1'b0;
            krep_q       <= 1'b0;
            held_q       <= 1'b0;
            held_code_q  <= 8'h00;
            held_ext_q   <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            gap_q        <= gap_d;
            skip_q       <= skip_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            nextdata_n_q <= nextdata_n_d;
            valid_q      <= valid_d;
            code_q       <= code_d;
            kext_q       <= kext_d;
            kbrk_q       <= kbrk_d;
            krep_q       <= krep_d;
            held_q       <= held_d;
            held_code_q  <= held_code_d;
            held_ext_q   <= held_ext_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign kbd_nextdata_n = nextdata_n_q;
    assign key_valid      = valid_q;
    assign key_code       = code_q;
    assign key_ext        = kext_q;
    assign key_break      = kbrk_q;
    assign key_repeat     = krep_q;
    assign key_held       = held_q;
    assign held_code      = held_code_q;
    assign press_count    = cnt_q;
    assign err_overflow   = err_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: byte sequences with hand-computed events.
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       kbd_ready;
    logic [7:0] kbd_data;
    logic       kbd_overflow;
    logic       kbd_nextdata_n;
    logic       clr_err;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_repeat;
    logic       key_held;
    logic [7:0] held_code;
    logic [7:0] press_count;
    logic       err_overflow;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int evs   = 0;
    int nev;
    int p0;

    ps2_key_ctrl #(.CNT_W(8), .POP_GAP(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .kbd_ready      (kbd_ready),
        .kbd_data       (kbd_data),
        .kbd_overflow   (kbd_overflow),
        .kbd_nextdata_n (kbd_nextdata_n),
        .clr_err        (clr_err),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_ext        (key_ext),
        .key_break      (key_break),
        .key_repeat     (key_repeat),
        .key_held       (key_held),
        .held_code      (held_code),
        .press_count    (press_count),
        .err_overflow   (err_overflow)
    );

    always #5 clk = ~clk;

    // Count pop strobe cycles and event strobes away from the active edge.
    always @(negedge clk) begin
        if (!kbd_nextdata_n) pops++;
        if (key_valid) evs++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        kbd_ready = 1'b0;
        kbd_overflow = 1'b0;
        clr_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one byte as FIFO head, drop ready after the pop, let it decode.
    task automatic send_byte(input logic [7:0] b, output int n_ev);
        int e0;
        int n;
        e0 = evs;
        kbd_data = b;
        kbd_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (kbd_nextdata_n !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        kbd_ready = 1'b0;
        if (n >= 20) check_val("pop_wait", n, 0);
        repeat (4) @(negedge clk);
        n_ev = evs - e0;
    endtask

    task automatic send_event(input string tag, input logic [7:0] b, input logic [7:0] code,
                              input logic ext, input logic brk, input logic rep);
        int n_ev;
        send_byte(b, n_ev);
        check_val({tag, "_nev"}, n_ev, 1);
        check_val({tag, "_code"}, key_code, code);
        check_val({tag, "_ext"}, key_ext, ext);
        check_val({tag, "_brk"}, key_break, brk);
        check_val({tag, "_rep"}, key_repeat, rep);
    endtask

    task automatic send_quiet(input string tag, input logic [7:0] b);
        int n_ev;
        send_byte(b, n_ev);
        check_val({tag, "_nev"}, n_ev, 0);
    endtask

    initial begin
        en = 1'b1;
        kbd_data = 8'h00;
        do_reset();

        // Reset state
        check_val("rst_nextdata_n", kbd_nextdata_n, 1);
        check_val("rst_valid", key_valid, 0);
        check_val("rst_code", key_code, 0);
        check_val("rst_held", key_held, 0);
        check_val("rst_count", press_count, 0);
        check_val("rst_err", err_overflow, 0);

        // 1C, F0, 1C
        p0 = pops;
        send_event("t1_make", 8'h1C, 8'h1C, 0, 0, 0);
        check_val("t1_held_a", key_held, 1);
        send_quiet("t1_f0", 8'hF0);
        send_event("t1_brk", 8'h1C, 8'h1C, 0, 1, 0);
        check_val("t1_held_b", key_held, 0);
        check_val("t1_count", press_count, 1);
        check_val("t1_pops", pops - p0, 3);

        // E0 75 E0 F0 75
        do_reset();
        send_quiet("t2_e0a", 8'hE0);
        send_event("t2_make", 8'h75, 8'h75, 1, 0, 0);
        send_quiet("t2_e0b", 8'hE0);
        send_quiet("t2_f0", 8'hF0);
        send_event("t2_brk", 8'h75, 8'h75, 1, 1, 0);
        check_val("t2_held", key_held, 0);

        // Typematic: 1C 1C 1C F0 1C
        do_reset();
        send_event("t3_m1", 8'h1C, 8'h1C, 0, 0, 0);
        send_event("t3_m2", 8'h1C, 8'h1C, 0, 0, 1);
        send_event("t3_m3", 8'h1C, 8'h1C, 0, 0, 1);
        send_quiet("t3_f0", 8'hF0);
        send_event("t3_brk", 8'h1C, 8'h1C, 0, 1, 0);
        check_val("t3_count", press_count, 1);
        check_val("t3_held", key_held, 0);

        // Rollover: 1C, 32, F0 1C
        do_reset();
        send_event("t4_m1", 8'h1C, 8'h1C, 0, 0, 0);
        send_event("t4_m2", 8'h32, 8'h32, 0, 0, 0);
        check_val("t4_hcode_a", held_code, 8'h32);
        send_quiet("t4_f0", 8'hF0);
        send_event("t4_brk", 8'h1C, 8'h1C, 0, 1, 0);
        check_val("t4_held", key_held, 1);
        check_val("t4_hcode_b", held_code, 8'h32);
        check_val("t4_count", press_count, 2);

        // Pause: E1 14 77 E1 F0 14 F0 77, then 1C
        do_reset();
        send_event("t5_e1", 8'hE1, 8'hE1, 0, 0, 0);
        send_quiet("t5_s1", 8'h14);
        send_quiet("t5_s2", 8'h77);
        send_quiet("t5_s3", 8'hE1);
        send_quiet("t5_s4", 8'hF0);
        send_quiet("t5_s5", 8'h14);
        send_quiet("t5_s6", 8'hF0);
        send_quiet("t5_s7", 8'h77);
        send_event("t5_make", 8'h1C, 8'h1C, 0, 0, 0);
        check_val("t5_count", press_count, 2);
        check_val("t5_hcode", held_code, 8'h1C);

        // Noise byte clears a pending E0
        do_reset();
        send_quiet("t6_e0", 8'hE0);
        send_quiet("t6_aa", 8'hAA);
        send_event("t6_make", 8'h1C, 8'h1C, 0, 0, 0);

        // Stall: no pops with en=0; E0 prefix survives the stall
        send_quiet("t7_e0", 8'hE0);
        en = 1'b0;
        p0 = pops;
        kbd_data = 8'h75;
        kbd_ready = 1'b1;
        repeat (6) @(negedge clk);
        check_val("t7_stall_pops", pops - p0, 0);
        kbd_ready = 1'b0;
        en = 1'b1;
        send_event("t7_make", 8'h75, 8'h75, 1, 0, 0);

        // Sticky overflow
        @(negedge clk);
        kbd_overflow = 1'b1;
        @(negedge clk);
        kbd_overflow = 1'b0;
        check_val("ovf_set", err_overflow, 1);
        repeat (3) @(negedge clk);
        check_val("ovf_sticky", err_overflow, 1);
        clr_err = 1'b1;
        kbd_overflow = 1'b1;
        @(negedge clk);
        check_val("ovf_set_wins", err_overflow, 1);
        kbd_overflow = 1'b0;
        @(negedge clk);
        clr_err = 1'b0;
        check_val("ovf_clr", err_overflow, 0);

        // Reset while in GAP
        do_reset();
        send_event("t8_make", 8'h1C, 8'h1C, 0, 0, 0);
        kbd_data = 8'h32;
        kbd_ready = 1'b1;
        @(negedge clk);
        check_val("t8_pop_low", kbd_nextdata_n, 0);
        kbd_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("t8_rst_nd", kbd_nextdata_n, 1);
        check_val("t8_rst_held", key_held, 0);
        check_val("t8_rst_count", press_count, 0);
        check_val("t8_rst_code", key_code, 0);
        @(negedge clk);
        rst = 1'b0;
        nev = evs;
        repeat (6) @(negedge clk);
        check_val("t8_no_event", evs - nev, 0);

        // Reset while the pop strobe is low returns it high at once
        kbd_data = 8'h32;
        kbd_ready = 1'b1;
        @(negedge clk);
        check_val("t9_pop_low", kbd_nextdata_n, 0);
        rst = 1'b1;
        #1;
        check_val("t9_rst_nd", kbd_nextdata_n, 1);
        kbd_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
